// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Registered multi-cycle ALU with NZCV flags, shifts and an
//             iterative shift-add multiplier behind start/ready/valid.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       ALUFlags
);

    localparam int             c_lg       = $clog2(WIDTH);
    localparam logic [c_lg-1:0] c_cnt_last = c_lg'(WIDTH - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_mul  = 1'b1;

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b011;
    localparam logic [2:0] c_op_mul = 3'b100;
    localparam logic [2:0] c_op_lsl = 3'b101;
    localparam logic [2:0] c_op_lsr = 3'b110;
    localparam logic [2:0] c_op_asr = 3'b111;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_acc;
    logic [c_lg-1:0]  r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic [c_lg-1:0]  w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_pp;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_last;

    // Shifts run one bit wider so the last bit shifted out lands in a fixed
    // position and becomes the carry; sh==0 naturally yields C=0.
    always_comb begin
        w_sh  = b[c_lg-1:0];
        w_sum = {1'b0, a} + {1'b0, b};
        w_dif = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        w_lsl = {1'b0, a} << w_sh;
        w_lsr = {a, 1'b0} >> w_sh;
        w_asr = $signed({a, 1'b0}) >>> w_sh;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (ALUControl)
            c_op_and: w_res = a & b;
            c_op_or:  w_res = a | b;
            c_op_add: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_lsl: begin
                w_res = w_lsl[WIDTH-1:0];
                w_c   = w_lsl[WIDTH];
            end
            c_op_lsr: begin
                w_res = w_lsr[WIDTH:1];
                w_c   = w_lsr[0];
            end
            c_op_asr: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            default: w_res = '0;
        endcase
    end

    // r_ma/r_mb shift each step, so r_ma always equals a << cnt
    always_comb begin
        w_pp       = r_mb[0] ? r_ma : '0;
        w_acc_next = r_acc + w_pp;
        w_mul_last = (r_cnt == c_cnt_last);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start && (ALUControl == c_op_mul)) w_state_next = c_st_mul;
            c_st_mul:  if (w_mul_last) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (ALUControl == c_op_mul) begin
                            r_ma  <= a;
                            r_mb  <= b;
                            r_acc <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_result <= w_res;
                            r_flags  <= {w_res[WIDTH-1], ~|w_res, w_c, w_v};
                            r_valid  <= 1'b1;
                        end
                    end
                end
                c_st_mul: begin
                    r_acc <= w_acc_next;
                    r_ma  <= r_ma << 1;
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + c_lg'(1);
                    if (w_mul_last) begin
                        r_result <= w_acc_next;
                        r_flags  <= {w_acc_next[WIDTH-1], ~|w_acc_next, 2'b00};
                        r_valid  <= 1'b1;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    always_comb begin
        ready    = (r_state == c_st_idle);
        valid    = r_valid;
        result   = r_result;
        ALUFlags = r_flags;
    end

endmodule
`default_nettype wire
